// File: rtl/crossbar_merge.sv
// crossbar_merge
//   Return-path collector for the CDMA router crossbar. Four user-side
//   streams are arbitrated round-robin onto one registered output channel.
//   Each beat is tagged with its source select (0..3 = user1..user4).
//
// Ports
//   clk                 single clock, rising-edge state updates
//   rst_n               asynchronous active-low reset
//   user1_in..user4_in  per-user data words (DATA_W bits)
//   user_valid[3:0]     per-user request, bit 0 = user1
//   user_ready[3:0]     per-user grant (combinational), bit 0 = user1
//   out_data            merged data word (registered)
//   out_sel[1:0]        source of out_data (registered)
//   out_valid           out_data/out_sel hold a beat
//   out_ready           downstream accepts the beat
module crossbar_merge #(
    parameter int unsigned DATA_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] user1_in,
    input  logic [DATA_W-1:0] user2_in,
    input  logic [DATA_W-1:0] user3_in,
    input  logic [DATA_W-1:0] user4_in,
    input  logic [3:0]        user_valid,
    output logic [3:0]        user_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        out_sel,
    output logic              out_valid,
    input  logic              out_ready
);

    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [1:0]        out_sel_q,  out_sel_d;
    logic              out_valid_q, out_valid_d;
    logic [1:0]        ptr_q,      ptr_d;

    logic              load;
    logic              found;
    logic [1:0]        win;
    logic [1:0]        idx;
    logic [DATA_W-1:0] win_data;

    always_comb begin
        load        = ~out_valid_q | out_ready;
        found       = 1'b0;
        win         = '0;
        idx         = '0;
        win_data    = '0;
        user_ready  = '0;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        out_valid_d = out_valid_q;
        ptr_d       = ptr_q;

        // Search ptr, ptr+1, ... (mod 4); the first requester wins.
        for (int unsigned i = 0; i < 4; i++) begin
            idx = ptr_q + 2'(i);
            if (!found && user_valid[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end

        case (win)
            2'd0:    win_data = user1_in;
            2'd1:    win_data = user2_in;
            2'd2:    win_data = user3_in;
            default: win_data = user4_in;
        endcase

        // Grant is suppressed while reset is asserted, even though the
        // cleared output register would otherwise make load true.
        if (load && found && rst_n) begin
            user_ready[win] = 1'b1;
        end

        if (load) begin
            if (found) begin
                out_data_d  = win_data;
                out_sel_d   = win;
                out_valid_d = 1'b1;
                ptr_d       = win + 2'd1;
            end else begin
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q  <= '0;
            out_sel_q   <= '0;
            out_valid_q <= 1'b0;
            ptr_q       <= '0;
        end else begin
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            out_valid_q <= out_valid_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;
    assign out_valid = out_valid_q;

endmodule
